// File: rtl/telemetry_pkg.sv
// telemetry_pkg: shared constants and FSM encoding for the telemetry UART arbiter
package telemetry_pkg;
  localparam logic [7:0] FRAME_HDR = 8'hA5;
  localparam logic [1:0] CH_SPO2 = 2'd0;
  localparam logic [1:0] CH_ENV = 2'd1;
  localparam logic [1:0] CH_STAT = 2'd2;
  localparam int MAX_LEN = 6;
  typedef enum logic [2:0] {S_IDLE, S_HDR, S_CHID, S_LEN, S_PAY, S_CSUM, S_DONE} state_t;
endpackage

// File: rtl/telemetry_uart_arbiter_ser.sv
// uart_byte_ser: 8N1 byte serializer, one byte per ready/valid handshake
module uart_byte_ser #(
  parameter int CLK_FRE = 50,
  parameter int BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ser_data,
  input  logic       ser_valid,
  output logic       ser_ready,
  output logic       uart_tx
);
  localparam int BIT_CYC = CLK_FRE * 1000000 / BAUD_RATE;
  localparam int CW = $clog2(BIT_CYC + 1);
  logic          active;
  logic [9:0]    sh;
  logic [3:0]    idx;
  logic [CW-1:0] cnt;
  assign ser_ready = !active;
  // shifting in ones leaves the line idle-high once the stop bit is gone
  assign uart_tx = sh[0];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      active <= 1'b0;
      sh <= '1;
      idx <= '0;
      cnt <= '0;
    end else if (!active) begin
      if (ser_valid) begin
        active <= 1'b1;
        sh <= {1'b1, ser_data, 1'b0};
        idx <= '0;
        cnt <= '0;
      end
    end else if (cnt == CW'(BIT_CYC - 1)) begin
      cnt <= '0;
      sh <= {1'b1, sh[9:1]};
      idx <= idx + 4'd1;
      if (idx == 4'd9) active <= 1'b0;
    end else cnt <= cnt + 1'b1;
endmodule

// File: rtl/telemetry_uart_arbiter.sv
// telemetry_uart_arbiter: round-robin capture of three telemetry payloads, framed
// as A5/ID/LEN/payload/CSUM onto one 8N1 UART line
module telemetry_uart_arbiter
  import telemetry_pkg::*;
#(
  parameter int CLK_FRE = 50,
  parameter int BAUD_RATE = 115200,
  parameter int LEN0 = 6,
  parameter int LEN1 = 2,
  parameter int LEN2 = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  req,
  input  logic [47:0] payload0,
  input  logic [47:0] payload1,
  input  logic [47:0] payload2,
  output logic        uart_tx,
  output logic        busy,
  output logic        frame_done,
  output logic [2:0]  overrun
);
  localparam int PW = MAX_LEN * 8;
  state_t        state, state_nx;
  logic [2:0]    pending, clr, len, cnt, g_len;
  logic [PW-1:0] hold [3];
  logic [PW-1:0] frame_buf;
  logic [1:0]    ptr, ch, c1, c2, g;
  logic [7:0]    csum, pay_byte, ser_data;
  logic          ser_valid, ser_ready, hs, grant;
  assign c1 = ptr == 2'd2 ? 2'd0 : ptr + 2'd1;
  assign c2 = c1 == 2'd2 ? 2'd0 : c1 + 2'd1;
  assign g = pending[c1] ? c1 : pending[c2] ? c2 : ptr;
  assign g_len = g == CH_SPO2 ? 3'(LEN0) : g == CH_ENV ? 3'(LEN1) : 3'(LEN2);
  assign pay_byte = frame_buf[{cnt, 3'b000} +: 8];
  always_comb begin
    grant = state == S_IDLE && |pending;
    clr = grant ? 3'(3'b001 << g) : 3'b000;
    ser_valid = state != S_IDLE && state != S_DONE;
    ser_data = state == S_HDR ? FRAME_HDR : state == S_CHID ? {6'd0, ch} :
               state == S_LEN ? {5'd0, len} : state == S_PAY ? pay_byte : csum;
    hs = ser_valid && ser_ready;
    state_nx = state;
    case (state)
      S_IDLE: if (grant) state_nx = S_HDR;
      S_HDR:  if (hs) state_nx = S_CHID;
      S_CHID: if (hs) state_nx = S_LEN;
      S_LEN:  if (hs) state_nx = S_PAY;
      S_PAY:  if (hs && cnt == 3'd0) state_nx = S_CSUM;
      S_CSUM: if (hs) state_nx = S_DONE;
      S_DONE: if (ser_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= S_IDLE;
      pending <= '0;
      overrun <= '0;
      ptr <= 2'd2;
      ch <= '0;
      len <= '0;
      cnt <= '0;
      csum <= '0;
      frame_buf <= '0;
      busy <= 1'b0;
      frame_done <= 1'b0;
      for (int i = 0; i < 3; i++) hold[i] <= '0;
    end else begin
      state <= state_nx;
      // a capture on the grant cycle re-arms the channel without counting as overrun
      pending <= (pending & ~clr) | req;
      overrun <= overrun | (req & pending & ~clr);
      frame_done <= state == S_DONE && ser_ready;
      if (req[0]) hold[0] <= payload0;
      if (req[1]) hold[1] <= payload1;
      if (req[2]) hold[2] <= payload2;
      if (grant) begin
        frame_buf <= hold[g];
        ch <= g;
        ptr <= g;
        len <= g_len;
        cnt <= g_len - 3'd1;
        csum <= {6'd0, g} + {5'd0, g_len};
        busy <= 1'b1;
      end
      if (state == S_PAY && hs) begin
        csum <= csum + pay_byte;
        cnt <= cnt - 3'd1;
      end
      if (state == S_DONE && ser_ready) busy <= 1'b0;
    end
  uart_byte_ser #(.CLK_FRE(CLK_FRE), .BAUD_RATE(BAUD_RATE)) u_ser (
    .clk(clk),
    .rst(rst),
    .ser_data(ser_data),
    .ser_valid(ser_valid),
    .ser_ready(ser_ready),
    .uart_tx(uart_tx)
  );
endmodule
